// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Avalon-style data bus between the memory access unit (master)
//            and the external data memory (slave).
// Signals  : bus_address     word address (low two bits always zero)
//            bus_read        read command
//            bus_write       write command
//            bus_byteenable  lane enables, lane n = bits [8n+7:8n]
//            bus_writedata   lane-replicated store data
//            bus_readdata    read data, valid in the accept cycle
//            bus_waitrequest slave not ready
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata;
  logic        bus_waitrequest;

  modport master (
    output bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
    input  bus_readdata, bus_waitrequest
  );

  modport slave (
    input  bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
    output bus_readdata, bus_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Executes LB/LBU/LH/LHU/LW and SB/SH/SW on an Avalon-style data
//            bus with waitrequest, stalling the core until the access ends
//            and returning the sign/zero-extended load result.
// Ports    : clk, reset         clock (rising edge), async active-high reset
//            mem_read/mem_write load/store request from the control unit
//            opcode, addr       instruction opcode and effective byte address
//            store_data         rt value for stores
//            stall              core must hold the current instruction
//            load_data          registered extended load result
//            done               one-cycle completion pulse
//            err                sticky error (bad request or bus timeout)
//            avm                Avalon master side of the data bus
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        mem_read,
  input  wire logic        mem_write,
  input  wire logic [5:0]  opcode,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] store_data,
  output logic             stall,
  output logic [31:0]      load_data,
  output logic             done,
  output logic             err,
  mem_access_unit_if.master avm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state;
  logic [15:0] wait_cnt;
  logic [16:0] wait_next;
  logic        timeout;

  // Attributes of the access in flight, latched when leaving IDLE
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic        lat_load;
  logic [1:0]  lat_lane;

  // Request decode (IDLE only)
  logic        req;
  logic        dec_load;
  logic        dec_store;
  logic [1:0]  dec_size;
  logic        dec_signed;
  logic        misaligned;
  logic        req_err;
  logic [3:0]  dec_be;
  logic [31:0] dec_wd;

  // Load extraction from the accept-cycle read data
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_size   = SZ_WORD;
    dec_signed = 1'b0;
    case (opcode)
      6'h20: begin dec_load  = 1'b1; dec_size = SZ_BYTE; dec_signed = 1'b1; end
      6'h21: begin dec_load  = 1'b1; dec_size = SZ_HALF; dec_signed = 1'b1; end
      6'h23: begin dec_load  = 1'b1; dec_size = SZ_WORD; end
      6'h24: begin dec_load  = 1'b1; dec_size = SZ_BYTE; end
      6'h25: begin dec_load  = 1'b1; dec_size = SZ_HALF; end
      6'h28: begin dec_store = 1'b1; dec_size = SZ_BYTE; end
      6'h29: begin dec_store = 1'b1; dec_size = SZ_HALF; end
      6'h2B: begin dec_store = 1'b1; dec_size = SZ_WORD; end
      default: ;
    endcase

    req        = mem_read | mem_write;
    misaligned = ((dec_size == SZ_HALF) && addr[0]) ||
                 ((dec_size == SZ_WORD) && (addr[1:0] != 2'b00));
    // A load strobe must carry a load opcode and a store strobe a store
    // opcode; anything else counts as an unmapped opcode.
    req_err    = req & ((mem_read & mem_write) |
                        (mem_read  & ~dec_load) |
                        (mem_write & ~dec_store) |
                        misaligned);

    case (dec_size)
      SZ_BYTE: begin
        dec_be = 4'b0001 << addr[1:0];
        dec_wd = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        dec_be = addr[1] ? 4'b1100 : 4'b0011;
        dec_wd = {2{store_data[15:0]}};
      end
      default: begin
        dec_be = 4'b1111;
        dec_wd = store_data;
      end
    endcase
  end

  always_comb begin
    case (lat_lane)
      2'd0:    byte_sel = avm.bus_readdata[7:0];
      2'd1:    byte_sel = avm.bus_readdata[15:8];
      2'd2:    byte_sel = avm.bus_readdata[23:16];
      default: byte_sel = avm.bus_readdata[31:24];
    endcase
    half_sel = lat_lane[1] ? avm.bus_readdata[31:16] : avm.bus_readdata[15:0];
    case (lat_size)
      SZ_BYTE: load_ext = {{24{lat_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{16{lat_signed & half_sel[15]}}, half_sel};
      default: load_ext = avm.bus_readdata;
    endcase
  end

  // Timeout fires on the WAIT_LIMIT-th consecutive waitrequest-high cycle.
  assign wait_next = {1'b0, wait_cnt} + 17'd1;
  assign timeout   = (WAIT_LIMIT != 0) && (32'(wait_next) >= WAIT_LIMIT);

  // Reset gates stall so it drops in the same instant as the bus commands,
  // even while the core is still presenting a request.
  assign stall = ~reset & (((state == IDLE) & req & ~req_err) | (state == BUS));
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      wait_cnt           <= 16'd0;
      lat_size           <= SZ_WORD;
      lat_signed         <= 1'b0;
      lat_load           <= 1'b0;
      lat_lane           <= 2'd0;
      load_data          <= 32'd0;
      err                <= 1'b0;
      avm.bus_address    <= 32'd0;
      avm.bus_read       <= 1'b0;
      avm.bus_write      <= 1'b0;
      avm.bus_byteenable <= 4'd0;
      avm.bus_writedata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (req_err) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              lat_size           <= dec_size;
              lat_signed         <= dec_signed;
              lat_load           <= mem_read;
              lat_lane           <= addr[1:0];
              avm.bus_address    <= {addr[31:2], 2'b00};
              avm.bus_byteenable <= dec_be;
              avm.bus_writedata  <= dec_wd;
              avm.bus_read       <= mem_read;
              avm.bus_write      <= mem_write;
              wait_cnt           <= 16'd0;
              state              <= BUS;
            end
          end
        end
        BUS: begin
          if (!avm.bus_waitrequest) begin
            avm.bus_read  <= 1'b0;
            avm.bus_write <= 1'b0;
            if (lat_load) begin
              load_data <= load_ext;
            end
            state <= DONE;
          end else if (timeout) begin
            avm.bus_read  <= 1'b0;
            avm.bus_write <= 1'b0;
            err           <= 1'b1;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_next[15:0];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit (WAIT_LIMIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit_if bif ();

  mem_access_unit #(.WAIT_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .opcode     (opcode),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .err        (err),
    .avm        (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          exp_rd;
    bit          exp_wr;
    int          exp_cycles;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    bit          chk_lanes;
    logic [31:0] exp_ld;
    logic        exp_err;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request, plays the slave with nwait waitrequest-high cycles,
  // and compares the popped expectation when done pulses.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdata,
                        input int nwait, input int exp_cycles,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input bit chk_lanes,
                        input logic [31:0] exp_ld, input logic exp_err);
    exp_t        e;
    int          bus_cyc = 0;
    bit          got = 0, rd_seen = 0, wr_seen = 0, stall_seen = 0, unstable = 0;
    logic        stall_in_done = 1'b0;
    logic [31:0] cap_addr = 32'd0, cap_wd = 32'd0;
    logic [3:0]  cap_be = 4'd0;

    e.tag = tag; e.exp_rd = rd; e.exp_wr = wr; e.exp_cycles = exp_cycles;
    e.exp_addr = exp_addr; e.exp_be = exp_be; e.exp_wd = exp_wd;
    e.chk_lanes = chk_lanes; e.exp_ld = exp_ld; e.exp_err = exp_err;

    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    opcode    = op;
    addr      = a;
    store_data = sd;
    bif.bus_waitrequest = 1'b1;
    bif.bus_readdata    = rdata;
    sb.push_back(e);

    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (stall) stall_seen = 1;
      if (bif.bus_read || bif.bus_write) begin
        bus_cyc++;
        if (bif.bus_read)  rd_seen = 1;
        if (bif.bus_write) wr_seen = 1;
        if (bus_cyc == 1) begin
          cap_addr = bif.bus_address;
          cap_be   = bif.bus_byteenable;
          cap_wd   = bif.bus_writedata;
        end else if (cap_addr !== bif.bus_address || cap_be !== bif.bus_byteenable ||
                     cap_wd !== bif.bus_writedata) begin
          unstable = 1;
        end
        bif.bus_waitrequest = (bus_cyc <= nwait);
      end
      if (done) begin
        got = 1;
        stall_in_done = stall;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    e = sb.pop_front();
    chk({e.tag, "/done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({e.tag, "/bus_read_seen"},  32'(rd_seen), 32'(e.exp_rd && e.exp_cycles > 0));
      chk({e.tag, "/bus_write_seen"}, 32'(wr_seen), 32'(e.exp_wr && e.exp_cycles > 0));
      chk({e.tag, "/bus_cycles"}, 32'(bus_cyc), 32'(e.exp_cycles));
      chk({e.tag, "/stall_seen"}, 32'(stall_seen), 32'(e.exp_cycles > 0));
      chk({e.tag, "/stall_in_done"}, 32'(stall_in_done), 32'd0);
      if (e.exp_cycles > 0) begin
        chk({e.tag, "/address"}, cap_addr, e.exp_addr);
        chk({e.tag, "/unstable"}, 32'(unstable), 32'd0);
        if (e.chk_lanes) begin
          chk({e.tag, "/byteenable"}, 32'(cap_be), 32'(e.exp_be));
          if (e.exp_wr) chk({e.tag, "/writedata"}, cap_wd, e.exp_wd);
        end
      end
      chk({e.tag, "/load_data"}, load_data, e.exp_ld);
      chk({e.tag, "/err"}, 32'(err), 32'(e.exp_err));
      @(negedge clk);
      #1;
      chk({e.tag, "/done_width"}, 32'(done), 32'd0);
    end
    bif.bus_waitrequest = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; opcode = 6'd0; addr = 32'd0; store_data = 32'd0;
    bif.bus_readdata = 32'd0;
    bif.bus_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst/stall", 32'(stall), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    chk("rst/load_data", load_data, 32'd0);
    chk("rst/bus_read", 32'(bif.bus_read), 32'd0);
    chk("rst/bus_write", 32'(bif.bus_write), 32'd0);
    chk("rst/bus_address", bif.bus_address, 32'd0);
    chk("rst/byteenable", 32'(bif.bus_byteenable), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //     tag      rd wr op     addr        sd            rdata         nw cyc addr        be       wd            lanes ld            err
    access("lw",    1, 0, 6'h23, 32'h104, 32'h0,        32'hDEADBEEF, 2, 3, 32'h104, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 0);
    access("lb",    1, 0, 6'h20, 32'h203, 32'h0,        32'h80112233, 0, 1, 32'h200, 4'b0000, 32'h0,        0, 32'hFFFFFF80, 0);
    access("lbu",   1, 0, 6'h24, 32'h203, 32'h0,        32'h80112233, 0, 1, 32'h200, 4'b0000, 32'h0,        0, 32'h00000080, 0);
    access("lhu",   1, 0, 6'h25, 32'h202, 32'h0,        32'h80112233, 1, 2, 32'h200, 4'b0000, 32'h0,        0, 32'h00008011, 0);
    access("lh_hi", 1, 0, 6'h21, 32'h202, 32'h0,        32'h80112233, 0, 1, 32'h200, 4'b0000, 32'h0,        0, 32'hFFFF8011, 0);
    access("lh_lo", 1, 0, 6'h21, 32'h200, 32'h0,        32'h80112233, 0, 1, 32'h200, 4'b0000, 32'h0,        0, 32'h00002233, 0);
    access("sb",    0, 1, 6'h28, 32'h11,  32'h000000A5, 32'h0,        0, 1, 32'h10,  4'b0010, 32'hA5A5A5A5, 1, 32'h00002233, 0);
    access("sh",    0, 1, 6'h29, 32'h22,  32'h1234BEEF, 32'h0,        1, 2, 32'h20,  4'b1100, 32'hBEEFBEEF, 1, 32'h00002233, 0);
    access("lw_to", 1, 0, 6'h23, 32'h40,  32'h0,        32'h11111111, 100, 4, 32'h40, 4'b1111, 32'h0,       1, 32'h00002233, 1);

    // Reset in the second BUS cycle of a store
    @(negedge clk);
    mem_write = 1'b1; opcode = 6'h2B; addr = 32'h50; store_data = 32'h55AA55AA;
    bif.bus_waitrequest = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid/bus_write_before", 32'(bif.bus_write), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid/bus_write", 32'(bif.bus_write), 32'd0);
    chk("rstmid/stall", 32'(stall), 32'd0);
    chk("rstmid/err", 32'(err), 32'd0);
    chk("rstmid/load_data", load_data, 32'd0);
    mem_write = 1'b0;
    bif.bus_waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    access("lw_post", 1, 0, 6'h23, 32'h60, 32'h0,        32'hCAFEF00D, 0, 1, 32'h60, 4'b1111, 32'h0,        1, 32'hCAFEF00D, 0);
    access("sh_mis",  0, 1, 6'h29, 32'h21, 32'h00001234, 32'h0,        0, 0, 32'h0,  4'b0000, 32'h0,        0, 32'hCAFEF00D, 1);
    access("sw_after",0, 1, 6'h2B, 32'h30, 32'h12345678, 32'h0,        1, 2, 32'h30, 4'b1111, 32'h12345678, 1, 32'hCAFEF00D, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
